mdio_responder: RTL and testbench
=================================

Name: mdio_responder

Overview:
- IEEE 802.3 Clause 22 MDIO management responder, i.e. the PHY-side slave for the TSE MAC MDIO master (mdc, mdio_in/mdio_out/mdio_oen).
- Lets on-FPGA logic present a PHY-like register space on a management bus, either as an emulated PHY or as a loopback target that exercises the MAC's MDIO driver without a real PHY.
- Oversamples MDC/MDIO in the system clock domain, decodes read and write frames, and exposes a simple register-access port to local logic.

Parameters:
- PREAMBLE_MIN, 32: consecutive 1 bits required before ST; 0 allows preamble suppression.
- ACCEPT_BCAST, 1: when 1, PHYAD 5'd0 is also accepted as a match.

Ports:
- clk  in  1  system clock; MDC must be at most clk/8.
- reset_n  in  1  asynchronous, active-low reset.
- phy_addr  in  5  this responder's PHY address; static.
- mdc  in  1  management clock from the master; asynchronous.
- mdio_in  in  1  MDIO pad input; asynchronous.
- mdio_out  out  1  MDIO drive value.
- mdio_oen  out  1  1 = release the pad (high-Z), 0 = drive mdio_out.
- reg_addr  out  5  REGAD of the current frame.
- reg_wr  out  1  one-clk pulse that commits a write.
- reg_wdata  out  16  write data; valid while reg_wr = 1.
- reg_rd  out  1  one-clk read-request pulse.
- reg_rdata  in  16  read data; must be stable one MDC period after reg_rd.
- frame_err  out  1  one-clk pulse on an aborted frame.

Behaviour:
- Reset values: mdio_oen=1, mdio_out=1, reg_wr=0, reg_rd=0, frame_err=0, reg_addr=0, reg_wdata=0, state IDLE, preamble count 0.
- Synchronisation: mdc and mdio_in each pass through a 2-FF synchroniser.
- An MDC rising edge is detected as synced mdc 0→1 and gives a one-clk strobe, rise. All frame logic advances only on rise; mdio_in is sampled on rise.
- Output timing: mdio_out/mdio_oen update 1 clk after rise, i.e. the PHY changes data after the rising edge and the master samples on the next one.
- Preamble counter: increments (saturating at 32) on each sampled 1; cleared on any sampled 0 outside the frame.
- IDLE: a sampled 0 while count >= PREAMBLE_MIN goes to ST; otherwise stay in IDLE.
- ST: expects 1 (ST=01). Anything else: frame_err, back to IDLE.
- OP: 2 bits, MSB first. 10 = read, 01 = write, 00/11 = frame_err and IDLE.
- PHYAD: 5 bits, MSB first. On mismatch (and not the broadcast 0 with ACCEPT_BCAST=1), go to IDLE silently with no frame_err; the data bits that follow contain zeros, so no false preamble can form.
- REGAD: 5 bits, then reg_addr updates.
- Read path:
  - On the rise that samples REGAD[0], pulse reg_rd.
  - TA bit 1: stay released.
  - On the next rise, latch reg_rdata into the shift register and drive mdio_oen=0, mdio_out=0 (TA bit 2).
  - On the following 16 rises, drive D15 down to D0.
  - On the rise after D0 is driven, mdio_oen=1; return to IDLE and clear the preamble counter.
- Write path:
  - TA must sample 1 then 0. Otherwise frame_err and IDLE.
  - Shift 16 data bits MSB first.
  - On the rise that samples D0, pulse reg_wr with reg_wdata; go to IDLE.
- mdio_oen=0 only between TA bit 2 and the end of D0 of a matched read.
- Contention (master driving during a read) is neither detected nor arbitrated.
- MDC stopping mid-frame: state holds indefinitely; no timeout.
- reset_n asserted mid-read: mdio_oen=1 immediately (asynchronous); no reg_wr is emitted.
- Back-to-back frames: with PREAMBLE_MIN=0, ST may follow on the very next bit.

Decomposition:
- Package mdio_pkg:
  - state enum: IDLE, ST, OP, PHYAD, REGAD, TA, WDATA, RDATA.
  - OP_READ=2'b10, OP_WRITE=2'b01.
  - ST_BITS=2'b01, TA_WRITE=2'b10.
  - MDIO_DATA_W=16.
- One sub-module, mdio_edge_sync: 2-FF synchronisers for mdc and mdio_in, plus the rise strobe.
- The frame FSM, bit counter and shift registers stay in mdio_responder.

Test Plan:
- Write frame: 32×1 preamble, ST=01, OP=01, PHYAD=5'h01 (phy_addr=1), REGAD=5'h04, TA=10, data 16'hA5C3 → exactly one reg_wr with reg_addr=4 and reg_wdata=16'hA5C3; mdio_oen stays 1 throughout.
- Read frame to REGAD=5'h02 with reg_rdata=16'h0141 → one reg_rd pulse; TA2 bit observed as 0; bits read back equal 16'h0141; mdio_oen=0 for exactly 17 MDC periods.
- PHYAD=5'h07 with phy_addr=1 → no reg_wr or reg_rd, mdio_oen stays 1, no frame_err; an immediately following valid frame to address 1 succeeds.
- Preamble of 31 ones with PREAMBLE_MIN=32 → frame ignored. OP=11 after a valid preamble → one frame_err pulse and no register access.
- Write with TA=11 → frame_err, no reg_wr. reset_n pulsed low during read data bit D8 → mdio_oen=1 within the reset; the next frame decodes normally.
- Read with ACCEPT_BCAST=1 and PHYAD=0 → responds with reg_rdata. The same frame with ACCEPT_BCAST=0 → silent.

Source files
------------

// File: rtl/mdio_pkg.sv
// rtl/mdio_pkg.sv - shared types and constants for the MDIO responder
// Purpose: frame FSM state encoding, Clause 22 field codes, data width and
//          the saturating preamble-count helper.
// Ports:   none (package).
package mdio_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ST,
    OP,
    PHYAD,
    REGAD,
    TA,
    WDATA,
    RDATA
  } mdio_state_e;

  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] ST_BITS  = 2'b01;
  localparam logic [1:0] TA_WRITE = 2'b10;
  localparam int         MDIO_DATA_W = 16;

  // Preamble counter saturates here; a larger PREAMBLE_MIN can never be met.
  localparam logic [5:0] PRE_SAT = 6'd32;

  function automatic logic [5:0] pre_inc(input logic [5:0] cnt);
    return (cnt >= PRE_SAT) ? PRE_SAT : cnt + 6'd1;
  endfunction

endpackage

// File: rtl/mdio_edge_sync.sv
// rtl/mdio_edge_sync.sv - MDC/MDIO synchronisers and MDC rising-edge strobe
// Purpose: bring the asynchronous management clock and data into the system
//          clock domain and flag each MDC rising edge with a one-clk strobe.
// Ports:
//   i_clk    system clock
//   i_rst_n  asynchronous active-low reset
//   i_mdc    raw MDC from the master
//   i_mdio   raw MDIO pad input
//   o_rise   one-clk strobe on a synced MDC 0->1 transition
//   o_mdio   synced MDIO value, valid to sample when o_rise is high
module mdio_edge_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_mdc,
  input  logic i_mdio,
  output logic o_rise,
  output logic o_mdio
);

  // [1:0] is the 2-FF synchroniser, [2] holds the previous synced value.
  logic [2:0] r_mdc_sync;
  logic [1:0] r_mdio_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mdc_sync  <= 3'b000;
      r_mdio_sync <= 2'b11;
    end else begin
      r_mdc_sync  <= {r_mdc_sync[1:0], i_mdc};
      r_mdio_sync <= {r_mdio_sync[0], i_mdio};
    end
  end

  assign o_rise = r_mdc_sync[1] & ~r_mdc_sync[2];
  assign o_mdio = r_mdio_sync[1];

endmodule

// File: rtl/mdio_responder.sv
// rtl/mdio_responder.sv - Clause 22 MDIO PHY-side responder with register port
// Purpose: decode MDIO read/write frames addressed to phy_addr (or broadcast 0)
//          and expose them as single-cycle register read/write requests.
// Ports:
//   clk, reset_n          system clock, asynchronous active-low reset
//   phy_addr              static PHY address of this responder
//   mdc, mdio_in          asynchronous management clock and pad input
//   mdio_out, mdio_oen    pad drive value and enable (1 = released)
//   reg_addr              REGAD of the current frame
//   reg_wr, reg_wdata     write commit pulse and its data
//   reg_rd, reg_rdata     read request pulse and returned data
//   frame_err             pulse on an aborted frame
module mdio_responder
  import mdio_pkg::*;
#(
  parameter int PREAMBLE_MIN = 32,
  parameter bit ACCEPT_BCAST = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [4:0]             phy_addr,
  input  logic                   mdc,
  input  logic                   mdio_in,
  output logic                   mdio_out,
  output logic                   mdio_oen,
  output logic [4:0]             reg_addr,
  output logic                   reg_wr,
  output logic [MDIO_DATA_W-1:0] reg_wdata,
  output logic                   reg_rd,
  input  logic [MDIO_DATA_W-1:0] reg_rdata,
  output logic                   frame_err
);

  localparam logic [5:0] PRE_MIN = 6'(PREAMBLE_MIN);

  logic w_rise;
  logic w_bit;

  mdio_edge_sync u_sync (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_mdc   (mdc),
    .i_mdio  (mdio_in),
    .o_rise  (w_rise),
    .o_mdio  (w_bit)
  );

  mdio_state_e            r_state;
  logic [5:0]             r_pre_cnt;
  logic [4:0]             r_bit_cnt;
  logic [MDIO_DATA_W-1:0] r_sh;
  logic                   r_is_read;

  logic [MDIO_DATA_W-1:0] w_sh_next;
  logic                   w_addr_match;

  assign w_sh_next    = {r_sh[MDIO_DATA_W-2:0], w_bit};
  assign w_addr_match = (w_sh_next[4:0] == phy_addr) ||
                        (ACCEPT_BCAST && (w_sh_next[4:0] == 5'd0));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_pre_cnt <= 6'd0;
      r_bit_cnt <= 5'd0;
      r_sh      <= '0;
      r_is_read <= 1'b0;
      mdio_out  <= 1'b1;
      mdio_oen  <= 1'b1;
      reg_addr  <= 5'd0;
      reg_wr    <= 1'b0;
      reg_wdata <= '0;
      reg_rd    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      reg_wr    <= 1'b0;
      reg_rd    <= 1'b0;
      frame_err <= 1'b0;
      if (w_rise) begin
        case (r_state)
          IDLE: begin
            // Ones are only counted here, so frame contents never look like preamble.
            if (w_bit) begin
              r_pre_cnt <= pre_inc(r_pre_cnt);
            end else begin
              r_pre_cnt <= 6'd0;
              if (r_pre_cnt >= PRE_MIN) r_state <= ST;
            end
          end
          ST: begin
            // The leading 0 of ST was consumed in IDLE; only the trailing 1 remains.
            r_bit_cnt <= 5'd0;
            if (w_bit == ST_BITS[0]) begin
              r_state <= OP;
            end else begin
              frame_err <= 1'b1;
              r_state   <= IDLE;
            end
          end
          OP: begin
            r_sh <= w_sh_next;
            if (r_bit_cnt == 5'd1) begin
              r_bit_cnt <= 5'd0;
              if (w_sh_next[1:0] == OP_READ) begin
                r_is_read <= 1'b1;
                r_state   <= PHYAD;
              end else if (w_sh_next[1:0] == OP_WRITE) begin
                r_is_read <= 1'b0;
                r_state   <= PHYAD;
              end else begin
                frame_err <= 1'b1;
                r_state   <= IDLE;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 5'd1;
            end
          end
          PHYAD: begin
            r_sh <= w_sh_next;
            if (r_bit_cnt == 5'd4) begin
              r_bit_cnt <= 5'd0;
              r_state   <= w_addr_match ? REGAD : IDLE;
            end else begin
              r_bit_cnt <= r_bit_cnt + 5'd1;
            end
          end
          REGAD: begin
            r_sh <= w_sh_next;
            if (r_bit_cnt == 5'd4) begin
              r_bit_cnt <= 5'd0;
              reg_addr  <= w_sh_next[4:0];
              reg_rd    <= r_is_read;
              r_state   <= TA;
            end else begin
              r_bit_cnt <= r_bit_cnt + 5'd1;
            end
          end
          TA: begin
            if (r_is_read) begin
              // TA bit 1 has just been released; drive the TA bit 2 zero now.
              r_sh      <= reg_rdata;
              mdio_oen  <= 1'b0;
              mdio_out  <= 1'b0;
              r_bit_cnt <= 5'd0;
              r_state   <= RDATA;
            end else begin
              r_sh <= w_sh_next;
              if (r_bit_cnt == 5'd1) begin
                r_bit_cnt <= 5'd0;
                if (w_sh_next[1:0] == TA_WRITE) begin
                  r_state <= WDATA;
                end else begin
                  frame_err <= 1'b1;
                  r_state   <= IDLE;
                end
              end else begin
                r_bit_cnt <= r_bit_cnt + 5'd1;
              end
            end
          end
          WDATA: begin
            r_sh <= w_sh_next;
            if (r_bit_cnt == 5'(MDIO_DATA_W - 1)) begin
              r_bit_cnt <= 5'd0;
              reg_wr    <= 1'b1;
              reg_wdata <= w_sh_next;
              r_state   <= IDLE;
            end else begin
              r_bit_cnt <= r_bit_cnt + 5'd1;
            end
          end
          RDATA: begin
            if (r_bit_cnt == 5'(MDIO_DATA_W)) begin
              mdio_oen  <= 1'b1;
              mdio_out  <= 1'b1;
              r_bit_cnt <= 5'd0;
              r_pre_cnt <= 6'd0;
              r_state   <= IDLE;
            end else begin
              mdio_out  <= r_sh[MDIO_DATA_W-1];
              r_sh      <= {r_sh[MDIO_DATA_W-2:0], 1'b0};
              r_bit_cnt <= r_bit_cnt + 5'd1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdio_responder.sv
// tb/tb_mdio_responder.sv - directed self-checking bench for mdio_responder
module tb_mdio_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mdc;
  logic        mdio_in;
  logic [4:0]  phy_addr;
  logic [15:0] reg_rdata;

  logic        a_out, a_oen, a_wr, a_rd, a_err;
  logic [4:0]  a_addr;
  logic [15:0] a_wdata;
  logic        b_out, b_oen, b_wr, b_rd, b_err;
  logic [4:0]  b_addr;
  logic [15:0] b_wdata;

  always #5 clk = ~clk;

  mdio_responder u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .phy_addr  (phy_addr),
    .mdc       (mdc),
    .mdio_in   (mdio_in),
    .mdio_out  (a_out),
    .mdio_oen  (a_oen),
    .reg_addr  (a_addr),
    .reg_wr    (a_wr),
    .reg_wdata (a_wdata),
    .reg_rd    (a_rd),
    .reg_rdata (reg_rdata),
    .frame_err (a_err)
  );

  mdio_responder #(.PREAMBLE_MIN(32), .ACCEPT_BCAST(1'b0)) u_dut_nb (
    .clk       (clk),
    .reset_n   (reset_n),
    .phy_addr  (phy_addr),
    .mdc       (mdc),
    .mdio_in   (mdio_in),
    .mdio_out  (b_out),
    .mdio_oen  (b_oen),
    .reg_addr  (b_addr),
    .reg_wr    (b_wr),
    .reg_wdata (b_wdata),
    .reg_rd    (b_rd),
    .reg_rdata (reg_rdata),
    .frame_err (b_err)
  );

  int n_assert = 0;
  int n_fail   = 0;

  int n_wr_a = 0, n_rd_a = 0, n_err_a = 0;
  int n_wr_b = 0, n_rd_b = 0, n_err_b = 0;
  logic [4:0]  last_addr_a  = 5'd0;
  logic [15:0] last_wdata_a = 16'd0;

  always @(negedge clk) begin
    if (a_wr) begin
      n_wr_a++;
      last_addr_a  = a_addr;
      last_wdata_a = a_wdata;
    end
    if (a_rd)  n_rd_a++;
    if (a_err) n_err_a++;
    if (b_wr)  n_wr_b++;
    if (b_rd)  n_rd_b++;
    if (b_err) n_err_b++;
  end

  logic [15:0] rd_data;
  logic        ta2;
  int          oen_low;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One MDC period: master sets data while MDC is low and samples just before the rise.
  task automatic mdio_cycle(input logic b, input int sel, input logic do_rst,
                            output logic s_out, output logic s_oen);
    mdc     = 1'b0;
    mdio_in = b;
    if (do_rst) begin
      #30 reset_n = 1'b0;
      #10 check("oen_during_reset", {31'd0, a_oen}, 32'd1);
      #10 reset_n = 1'b1;
      #28;
    end else begin
      #78;
    end
    s_out = (sel != 0) ? b_out : a_out;
    s_oen = (sel != 0) ? b_oen : a_oen;
    #2 mdc = 1'b1;
    #80;
  endtask

  task automatic frame(input int pre, input logic [1:0] st, input logic [1:0] op,
                       input logic [4:0] pa, input logic [4:0] ra, input logic [1:0] ta,
                       input logic [15:0] wd, input int sel, input int rst_bit);
    logic [13:0] hdr;
    logic [17:0] dp;
    logic        o, e;
    oen_low = 0;
    rd_data = 16'd0;
    ta2     = 1'b1;
    hdr = {st, op, pa, ra};
    dp  = (op == 2'b10) ? 18'h3FFFF : {ta, wd};
    for (int i = 0; i < pre; i++) begin
      mdio_cycle(1'b1, sel, 1'b0, o, e);
      if (!e) oen_low++;
    end
    for (int i = 13; i >= 0; i--) begin
      mdio_cycle(hdr[i], sel, 1'b0, o, e);
      if (!e) oen_low++;
    end
    for (int i = 0; i < 18; i++) begin
      mdio_cycle(dp[17-i], sel, (i == rst_bit), o, e);
      if (!e) oen_low++;
      if (i == 1) ta2 = o;
      if (i >= 2) rd_data = {rd_data[14:0], o};
    end
    mdc = 1'b0;
    #80;
  endtask

  int s_wr, s_rd, s_err, s_rdb, s_errb;

  task automatic snap();
    s_wr   = n_wr_a;
    s_rd   = n_rd_a;
    s_err  = n_err_a;
    s_rdb  = n_rd_b;
    s_errb = n_err_b;
  endtask

  initial begin
    reset_n   = 1'b0;
    mdc       = 1'b0;
    mdio_in   = 1'b1;
    phy_addr  = 5'd1;
    reg_rdata = 16'h0000;
    #100;
    check("rst_oen",   {31'd0, a_oen},   32'd1);
    check("rst_out",   {31'd0, a_out},   32'd1);
    check("rst_wr",    {31'd0, a_wr},    32'd0);
    check("rst_rd",    {31'd0, a_rd},    32'd0);
    check("rst_err",   {31'd0, a_err},   32'd0);
    check("rst_addr",  {27'd0, a_addr},  32'd0);
    check("rst_wdata", {16'd0, a_wdata}, 32'd0);
    reset_n = 1'b1;
    #50;

    // Write 16'hA5C3 to register 4
    snap();
    frame(32, 2'b01, 2'b01, 5'h01, 5'h04, 2'b10, 16'hA5C3, 0, -1);
    check("wr_count",   n_wr_a - s_wr, 1);
    check("wr_addr",    {27'd0, last_addr_a}, 32'h4);
    check("wr_data",    {16'd0, last_wdata_a}, 32'hA5C3);
    check("wr_oen_low", oen_low, 0);
    check("wr_no_err",  n_err_a - s_err, 0);
    check("wr_no_rd",   n_rd_a - s_rd, 0);

    // Read register 2 returning 16'h0141
    reg_rdata = 16'h0141;
    snap();
    frame(32, 2'b01, 2'b10, 5'h01, 5'h02, 2'b11, 16'h0000, 0, -1);
    check("rd_count",   n_rd_a - s_rd, 1);
    check("rd_addr",    {27'd0, a_addr}, 32'h2);
    check("rd_ta2",     {31'd0, ta2}, 32'd0);
    check("rd_data",    {16'd0, rd_data}, 32'h0141);
    check("rd_oen_low", oen_low, 17);
    check("rd_release", {31'd0, a_oen}, 32'd1);
    check("rd_no_wr",   n_wr_a - s_wr, 0);

    // PHYAD mismatch, then an immediate valid write
    snap();
    frame(32, 2'b01, 2'b01, 5'h07, 5'h04, 2'b10, 16'h1234, 0, -1);
    check("mis_no_wr",  n_wr_a - s_wr, 0);
    check("mis_no_rd",  n_rd_a - s_rd, 0);
    check("mis_no_err", n_err_a - s_err, 0);
    check("mis_oen",    oen_low, 0);
    snap();
    frame(32, 2'b01, 2'b01, 5'h01, 5'h05, 2'b10, 16'h5A0F, 0, -1);
    check("post_mis_wr",   n_wr_a - s_wr, 1);
    check("post_mis_addr", {27'd0, last_addr_a}, 32'h5);
    check("post_mis_data", {16'd0, last_wdata_a}, 32'h5A0F);

    // Short preamble of 31 ones is ignored
    snap();
    frame(31, 2'b01, 2'b01, 5'h01, 5'h06, 2'b10, 16'h7777, 0, -1);
    check("pre31_no_wr",  n_wr_a - s_wr, 0);
    check("pre31_no_err", n_err_a - s_err, 0);

    // OP=11 aborts with one frame_err
    snap();
    frame(32, 2'b01, 2'b11, 5'h01, 5'h04, 2'b10, 16'h0000, 0, -1);
    check("op11_err",   n_err_a - s_err, 1);
    check("op11_no_wr", n_wr_a - s_wr, 0);
    check("op11_no_rd", n_rd_a - s_rd, 0);

    // Write with bad turnaround 11
    snap();
    frame(32, 2'b01, 2'b01, 5'h01, 5'h04, 2'b11, 16'hFFFF, 0, -1);
    check("ta11_err",   n_err_a - s_err, 1);
    check("ta11_no_wr", n_wr_a - s_wr, 0);

    // Reset during read data bit D8, then a clean read
    reg_rdata = 16'hC3A5;
    snap();
    frame(32, 2'b01, 2'b10, 5'h01, 5'h03, 2'b11, 16'h0000, 0, 9);
    check("rst_rd_oen",   {31'd0, a_oen}, 32'd1);
    check("rst_rd_no_wr", n_wr_a - s_wr, 0);
    reg_rdata = 16'h0F0F;
    snap();
    frame(32, 2'b01, 2'b10, 5'h01, 5'h03, 2'b11, 16'h0000, 0, -1);
    check("after_rst_rd",   n_rd_a - s_rd, 1);
    check("after_rst_data", {16'd0, rd_data}, 32'h0F0F);
    check("after_rst_oen",  oen_low, 17);

    // Broadcast PHYAD 0: answered with ACCEPT_BCAST=1, silent with 0
    reg_rdata = 16'hBEEF;
    snap();
    frame(32, 2'b01, 2'b10, 5'h00, 5'h02, 2'b11, 16'h0000, 0, -1);
    check("bcast_rd",   n_rd_a - s_rd, 1);
    check("bcast_data", {16'd0, rd_data}, 32'hBEEF);
    check("bcast_oen",  oen_low, 17);
    snap();
    frame(32, 2'b01, 2'b10, 5'h00, 5'h02, 2'b11, 16'h0000, 1, -1);
    check("nobcast_oen",    oen_low, 0);
    check("nobcast_no_rd",  n_rd_b - s_rdb, 0);
    check("nobcast_no_err", n_err_b - s_errb, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
